line_framer: RTL and testbench
==============================

# line_framer

Packetises the CCD pixel stream into framed scan lines for the USB TX path. It sits between the CCD timing/ADC stage (pixel producer) and the data formatter / FT232H TX FIFO (consumer). Each accepted line is emitted as a header, then the payload, then a checksum trailer. A line is admitted only if the downstream FIFO can absorb it whole; otherwise it is dropped and counted.

## Interface
- PIX_PER_LINE, 3648, payload pixels per line (1..65535)
- SYNC_WORD, 16'hA55A, first header word
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- en  in  1  line admission enable; sampled only at start of line
- pix_valid  in  1  one-cycle strobe, pix_data valid
- pix_sol  in  1  start-of-line; meaningful only with pix_valid (marks first pixel of a line)
- pix_data  in  16  pixel sample
- tx_space  in  16  free words in downstream FIFO
- tx_valid  out  1  one-cycle write strobe to downstream FIFO
- tx_data  out  16  output word, valid with tx_valid
- line_cnt  out  16  lines admitted since reset, wraps at 2^16
- drop_cnt  out  16  lines dropped since reset, saturates at 16'hFFFF
- err_short  out  1  sticky: a line ended early (new sol before PIX_PER_LINE pixels)

## Operation
- Frame format, in order: SYNC_WORD, line number (line_cnt value before increment), PIX_PER_LINE, pixel words, checksum. Checksum = 16-bit sum mod 2^16 of all payload pixels.
- States: IDLE, HDR_SYNC, HDR_LINE, HDR_CNT, PIX0, STREAM, TRAILER, SKIP.
- IDLE and SKIP, on pix_valid & pix_sol:
  - Admit when en=1 and tx_space >= PIX_PER_LINE+4. Compare in 17 bits, no overflow. On admit: hold pixel, sum = pix_data, pcount = 1, line_cnt++, go to HDR_SYNC.
  - Otherwise: drop_cnt++ (saturating), go to SKIP.
- IDLE ignores pix_valid without sol. SKIP ignores all pixels until the next sol.
- Header sequence:
  - HDR_SYNC emits SYNC_WORD, then HDR_LINE.
  - HDR_LINE emits the line number, then HDR_CNT.
  - HDR_CNT emits PIX_PER_LINE, then PIX0.
  - PIX0 emits the held pixel. It goes to TRAILER if PIX_PER_LINE==1, else STREAM.
- STREAM, on pix_valid & ~pix_sol: emit pixel next cycle, sum += pix_data, pcount++. When pcount reaches PIX_PER_LINE, go to TRAILER.
- STREAM, on pix_valid & pix_sol (short line):
  - Set err_short.
  - drop_cnt++ for the new line; its sol pixel is discarded.
  - Go to TRAILER with the inverted flag set.
- TRAILER emits sum, or ~sum if the inverted flag is set, then returns to IDLE. The next line starts at the next sol.
- en deassertion mid-frame has no effect; the frame completes.
- Reset: state IDLE. tx_valid=0, tx_data=0, line_cnt=0, drop_cnt=0, err_short=0, sum=0, pcount=0. Reset mid-frame abandons the frame with no trailer.

## Timing
- Precondition: consecutive pix_valid strobes are at least 5 cycles apart (the ADC serial readout gives ≥16). A violation during header states is undefined; the bench does not drive it.
- All outputs registered.
- sol pixel accepted at cycle N:
  - SYNC_WORD at N+1
  - line number at N+2
  - count at N+3
  - pixel0 at N+4
- Later pixel with pix_valid at cycle M: tx_data at M+1.
- Trailer: one cycle after the last pixel word.
- Short-line trailer: cycle M+1 for the offending sol at M.
- tx_valid is high exactly one cycle per word. No backpressure; admission guarantees space.
- line_cnt/drop_cnt update at N+1. err_short sets at M+1.

## Test plan
- PIX_PER_LINE=4, tx_space=100, sol + pixels 1,2,3,4 spaced 8 cycles -> words A55A,0000,0004,0001,0002,0003,0004,000A. line_cnt=1. Each word at the latency above.
- Two back-to-back lines (PIX_PER_LINE=4), second with pixels FFFF×4 -> second header line number 0001, trailer FFFC (wrap). line_cnt=2.
- tx_space=7 (needs 8) at sol -> no tx_valid for that line, drop_cnt=1. The following pixels produce no output. Next sol with tx_space=8 is admitted.
- en=0 at sol -> line dropped, drop_cnt=1. Deassert en mid-frame -> frame completes with trailer.
- Short line: sol, pixels 5,6, then sol -> trailer ~000B=FFF4, err_short=1, drop_cnt=1. The next sol frames normally with line number 0001.
- rst asserted during STREAM -> next cycle all outputs 0, state IDLE. A following sol produces header line number 0000.

Source files
------------

// File: rtl/line_framer.sv
// Frames CCD scan lines for the USB TX path: header (sync, line number, pixel
// count), payload pixels, then a 16-bit checksum trailer.
module line_framer #(
  parameter int unsigned PIX_PER_LINE = 3648,
  parameter logic [15:0] SYNC_WORD    = 16'hA55A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pix_valid,
  input  logic        pix_sol,
  input  logic [15:0] pix_data,
  input  logic [15:0] tx_space,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  output logic [15:0] line_cnt,
  output logic [15:0] drop_cnt,
  output logic        err_short,
  output logic [2:0]  dbg_state
);

  // Handshake: pix_valid and tx_valid are single-cycle strobes with no ready;
  // a line is only admitted when tx_space guarantees the whole frame fits.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_SYNC = 3'd1,
    HDR_LINE = 3'd2,
    HDR_CNT  = 3'd3,
    PIX0     = 3'd4,
    STREAM   = 3'd5,
    TRAILER  = 3'd6,
    SKIP     = 3'd7
  } state_t;

  localparam logic [16:0] NEED_SPACE = 17'(PIX_PER_LINE + 4);
  localparam logic [15:0] PPL        = 16'(PIX_PER_LINE);

  state_t      state_q;
  logic        tx_valid_q;
  logic [15:0] tx_data_q;
  logic [15:0] line_cnt_q;
  logic [15:0] drop_cnt_q;
  logic        err_short_q;
  logic [15:0] sum_q;
  logic [15:0] pcount_q;
  logic [15:0] hold_q;

  logic        sol_d;
  logic        pix_d;
  logic        admit_d;
  logic [15:0] sum_d;
  logic [15:0] drop_inc_d;

  always_comb begin
    sol_d      = pix_valid & pix_sol;
    pix_d      = pix_valid & ~pix_sol;
    admit_d    = en && ({1'b0, tx_space} >= NEED_SPACE);
    sum_d      = sum_q + pix_data;
    drop_inc_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
  end

  // The state names the word currently on tx_data; each word is registered
  // at the edge that leaves the previous state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 16'd0;
      line_cnt_q  <= 16'd0;
      drop_cnt_q  <= 16'd0;
      err_short_q <= 1'b0;
      sum_q       <= 16'd0;
      pcount_q    <= 16'd0;
      hold_q      <= 16'd0;
    end else begin
      tx_valid_q <= 1'b0;
      case (state_q)
        IDLE, SKIP: begin
          if (sol_d) begin
            if (admit_d) begin
              hold_q     <= pix_data;
              sum_q      <= pix_data;
              pcount_q   <= 16'd1;
              line_cnt_q <= line_cnt_q + 16'd1;
              tx_valid_q <= 1'b1;
              tx_data_q  <= SYNC_WORD;
              state_q    <= HDR_SYNC;
            end else begin
              drop_cnt_q <= drop_inc_d;
              state_q    <= SKIP;
            end
          end
        end
        HDR_SYNC: begin
          // line_cnt already advanced on admission; the header carries the old value
          tx_valid_q <= 1'b1;
          tx_data_q  <= line_cnt_q - 16'd1;
          state_q    <= HDR_LINE;
        end
        HDR_LINE: begin
          tx_valid_q <= 1'b1;
          tx_data_q  <= PPL;
          state_q    <= HDR_CNT;
        end
        HDR_CNT: begin
          tx_valid_q <= 1'b1;
          tx_data_q  <= hold_q;
          state_q    <= PIX0;
        end
        PIX0: begin
          if (PPL == 16'd1) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= sum_q;
            state_q    <= TRAILER;
          end else begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (pcount_q == PPL) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= sum_q;
            state_q    <= TRAILER;
          end else if (pix_d) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= pix_data;
            sum_q      <= sum_d;
            pcount_q   <= pcount_q + 16'd1;
          end else if (sol_d) begin
            // Short line: close it with an inverted checksum and drop the new line
            err_short_q <= 1'b1;
            drop_cnt_q  <= drop_inc_d;
            tx_valid_q  <= 1'b1;
            tx_data_q   <= ~sum_q;
            state_q     <= TRAILER;
          end
        end
        TRAILER: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign line_cnt  = line_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_short = err_short_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_line_framer.sv
// Bench for line_framer: a reference model pushes {cycle, word} expectations
// when pixels are driven, and a monitor pops and compares every tx word.
module tb_line_framer;

  localparam int PPL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pix_valid;
  logic        pix_sol;
  logic [15:0] pix_data;
  logic [15:0] tx_space;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic [15:0] line_cnt;
  logic [15:0] drop_cnt;
  logic        err_short;
  logic [2:0]  dbg_state;

  line_framer #(.PIX_PER_LINE(PPL), .SYNC_WORD(16'hA55A)) dut (
    .clk(clk), .rst(rst), .en(en), .pix_valid(pix_valid), .pix_sol(pix_sol),
    .pix_data(pix_data), .tx_space(tx_space), .tx_valid(tx_valid),
    .tx_data(tx_data), .line_cnt(line_cnt), .drop_cnt(drop_cnt),
    .err_short(err_short), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [47:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  logic [15:0] m_line;
  logic [15:0] m_drop;
  logic [15:0] m_sum;
  logic        m_err;
  int          m_pcount;
  bit          m_in_frame;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input int unsigned at, input logic [15:0] w);
    exp_q.push_back({at, w});
  endtask

  task automatic model_clear();
    m_line     = 16'd0;
    m_drop     = 16'd0;
    m_sum      = 16'd0;
    m_err      = 1'b0;
    m_pcount   = 0;
    m_in_frame = 1'b0;
  endtask

  task automatic model_drop();
    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
  endtask

  // monitor: every tx word must match the head of the queue, including its cycle
  always @(negedge clk) begin
    if (!rst && tx_valid === 1'b1) begin
      if (exp_q.size() == 0) check("tx_unexpected", 48'(exp_q.size()), 48'd1);
      else check("tx_word", {cyc, tx_data}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_sol   = 1'b0;
    exp_q.delete();
    model_clear();
    @(posedge clk); #1;
    check("rst_tx_valid",  48'(tx_valid),  48'd0);
    check("rst_tx_data",   48'(tx_data),   48'd0);
    check("rst_line_cnt",  48'(line_cnt),  48'd0);
    check("rst_drop_cnt",  48'(drop_cnt),  48'd0);
    check("rst_err_short", 48'(err_short), 48'd0);
    check("rst_state",     48'(dbg_state), 48'd0);
    rst = 1'b0;
  endtask

  // Drive one strobe; the next strobe comes `gap` cycles later (gap >= 5).
  task automatic drive(input bit sol, input logic [15:0] data, input int gap);
    int unsigned n;
    @(posedge clk); #1;
    pix_valid = 1'b1;
    pix_sol   = sol;
    pix_data  = data;
    n         = cyc;
    if (sol) begin
      if (m_in_frame) begin
        m_err = 1'b1;
        model_drop();
        push_word(n + 1, ~m_sum);
        m_in_frame = 1'b0;
      end else if (en && ({1'b0, tx_space} >= 17'(PPL + 4))) begin
        push_word(n + 1, 16'hA55A);
        push_word(n + 2, m_line);
        push_word(n + 3, 16'(PPL));
        push_word(n + 4, data);
        m_line     = m_line + 16'd1;
        m_sum      = data;
        m_pcount   = 1;
        m_in_frame = 1'b1;
      end else begin
        model_drop();
      end
    end else if (m_in_frame) begin
      m_sum    = m_sum + data;
      m_pcount = m_pcount + 1;
      push_word(n + 1, data);
      if (m_pcount == PPL) begin
        push_word(n + 2, m_sum);
        m_in_frame = 1'b0;
      end
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sol   = 1'b0;
    repeat (gap - 2) @(posedge clk);
  endtask

  task automatic send_line(input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic [15:0] p3);
    drive(1'b1, p0, 8);
    drive(1'b0, p1, 8);
    drive(1'b0, p2, 8);
    drive(1'b0, p3, 8);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (12) @(posedge clk);
    #1;
    check({tag, "_drained"},  48'(exp_q.size()), 48'd0);
    check({tag, "_line_cnt"}, 48'(line_cnt),     48'(m_line));
    check({tag, "_drop_cnt"}, 48'(drop_cnt),     48'(m_drop));
    check({tag, "_err"},      48'(err_short),    48'(m_err));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b0;
    en        = 1'b1;
    pix_valid = 1'b0;
    pix_sol   = 1'b0;
    pix_data  = 16'd0;
    tx_space  = 16'd100;
    model_clear();

    do_reset();

    // basic line: A55A,0000,0004,0001..0004,000A
    send_line(16'd1, 16'd2, 16'd3, 16'd4);
    settle_and_check("basic");

    // second line with wrapping checksum (FFFC), header line number 0001
    send_line(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    settle_and_check("wrap");

    // one word short of room -> dropped; exactly enough room -> admitted
    tx_space = 16'd7;
    send_line(16'd11, 16'd12, 16'd13, 16'd14);
    settle_and_check("space7");
    tx_space = 16'd8;
    send_line(16'd21, 16'd22, 16'd23, 16'd24);
    settle_and_check("space8");
    tx_space = 16'd100;

    // en low at sol drops the line; en falling mid-frame does not
    en = 1'b0;
    send_line(16'd31, 16'd32, 16'd33, 16'd34);
    en = 1'b1;
    drive(1'b1, 16'd41, 8);
    en = 1'b0;
    drive(1'b0, 16'd42, 8);
    drive(1'b0, 16'd43, 8);
    drive(1'b0, 16'd44, 8);
    en = 1'b1;
    settle_and_check("enable");

    // short line: 5,6 then sol -> trailer FFF4; stray pixel afterwards ignored
    drive(1'b1, 16'd5, 8);
    drive(1'b0, 16'd6, 8);
    drive(1'b1, 16'd9, 8);
    drive(1'b0, 16'd7, 8);
    settle_and_check("short");
    send_line(16'h1234, 16'h0F0F, 16'h8000, 16'h8001);
    settle_and_check("after_short");

    // reset in the middle of STREAM abandons the frame
    drive(1'b1, 16'd51, 8);
    drive(1'b0, 16'd52, 8);
    do_reset();
    send_line(16'd61, 16'd62, 16'd63, 16'd64);
    settle_and_check("after_rst");

    // randomised lines: space near threshold, occasional en low, variable gaps
    for (int l = 0; l < 8; l++) begin
      tx_space = 16'($urandom_range(6, 10));
      en       = ($urandom_range(0, 3) != 0);
      drive(1'b1, 16'($urandom_range(0, 16'hFFFF)), $urandom_range(5, 12));
      en = 1'b1;
      for (int k = 1; k < PPL; k++) begin
        if (k == 3 && $urandom_range(0, 4) == 0)
          drive(1'b1, 16'($urandom_range(0, 16'hFFFF)), $urandom_range(5, 12));
        else
          drive(1'b0, 16'($urandom_range(0, 16'hFFFF)), $urandom_range(5, 12));
      end
    end
    tx_space = 16'd100;
    settle_and_check("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
